// File: rtl/ahb3lite_master_if.sv
// ahb3lite_pkg bus types plus the command/bus interface of ahb3lite_master.
// cmd_hold is present only when AHB_MASTER_BUSY_EN is defined.
package ahb3lite_pkg;
  typedef enum logic [2:0] {
    SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
    WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
  } HBURST_Type;
  typedef enum logic [1:0] {
    IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3
  } HTRANS_state;
  typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} HRESP_state;
endpackage

interface ahb3lite_master_if
  import ahb3lite_pkg::*;
#(
  parameter int MAX_LEN = 16
);
  localparam int LW = $clog2(MAX_LEN) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [31:0]       cmd_addr;
  logic              cmd_write;
  HBURST_Type        cmd_burst;
  logic [2:0]        cmd_size;
  logic [LW-1:0]     cmd_len;
`ifdef AHB_MASTER_BUSY_EN
  logic              cmd_hold;
`endif
  logic [31:0]       wr_data;
  logic              wr_data_req;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              done;
  logic              error;
  logic [31:0]       HADDR;
  HBURST_Type        HBURST;
  logic [2:0]        HSIZE;
  HTRANS_state       HTRANS;
  logic              HWRITE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  HRESP_state        HRESP;
  logic [31:0]       HRDATA;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write,
    input  cmd_burst, cmd_size, cmd_len,
`ifdef AHB_MASTER_BUSY_EN
    input  cmd_hold,
`endif
    input  wr_data, HREADY, HRESP, HRDATA,
    output cmd_ready, wr_data_req,
    output rd_data, rd_valid, done, error,
    output HADDR, HBURST, HSIZE, HTRANS,
    output HWRITE, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write,
    output cmd_burst, cmd_size, cmd_len,
`ifdef AHB_MASTER_BUSY_EN
    output cmd_hold,
`endif
    output wr_data, HREADY, HRESP, HRDATA,
    input  cmd_ready, wr_data_req,
    input  rd_data, rd_valid, done, error,
    input  HADDR, HBURST, HSIZE, HTRANS,
    input  HWRITE, HWDATA
  );
endinterface

// File: rtl/ahb3lite_master.sv
// AHB-Lite burst master with pipelined address/data phases.
// Define AHB_MASTER_BUSY_EN to add cmd_hold and BUSY insertion.
module ahb3lite_master
  import ahb3lite_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input logic HCLK,
  input logic HRESET,
  ahb3lite_master_if.master bus
);
  localparam int LW = $clog2(MAX_LEN) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR
  } state_t;

  state_t      state_q;
  logic [31:0] haddr_q;
  HBURST_Type  hburst_q;
  logic [2:0]  hsize_q;
  HTRANS_state htrans_q;
  logic        hwrite_q;
  logic [31:0] hwdata_q;
  logic [31:0] rd_data_q;
  logic        rd_valid_q;
  logic        done_q;
  logic        error_q;
  logic        wreq_q;
  logic [LW-1:0] left_q;
  logic        dph_q;

  logic          hold;
  logic          act;
  logic [LW-1:0] beats_d;
  logic [31:0]   incr;
  logic [31:0]   wmask;
  logic [31:0]   addr_d;

`ifdef AHB_MASTER_BUSY_EN
  assign hold = bus.cmd_hold;
`else
  assign hold = 1'b0;
`endif

  assign act = (htrans_q == NONSEQ) ||
               (htrans_q == SEQ);

  always_comb begin
    beats_d = LW'(1);
    unique case (bus.cmd_burst)
      INCR: begin
        if (bus.cmd_len != '0)
          beats_d = bus.cmd_len;
      end
      WRAP4, INCR4:   beats_d = LW'(4);
      WRAP8, INCR8:   beats_d = LW'(8);
      WRAP16, INCR16: beats_d = LW'(16);
      default:        beats_d = LW'(1);
    endcase
  end

  // Wrapping bursts keep the bits above the wrap boundary fixed.
  always_comb begin
    incr  = 32'd1 << hsize_q;
    wmask = '1;
    unique case (1'b1)
      hburst_q == WRAP4:  wmask = (incr << 2) - 32'd1;
      hburst_q == WRAP8:  wmask = (incr << 3) - 32'd1;
      hburst_q == WRAP16: wmask = (incr << 4) - 32'd1;
      default: ;
    endcase
    addr_d = (haddr_q & ~wmask) |
             ((haddr_q + incr) & wmask);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      haddr_q    <= '0;
      hburst_q   <= SINGLE;
      hsize_q    <= '0;
      htrans_q   <= IDLE;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      wreq_q     <= 1'b0;
      left_q     <= '0;
      dph_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      wreq_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            haddr_q  <= bus.cmd_addr;
            hburst_q <= bus.cmd_burst;
            hsize_q  <= bus.cmd_size;
            hwrite_q <= bus.cmd_write;
            htrans_q <= NONSEQ;
            left_q   <= beats_d - 1'b1;
            error_q  <= 1'b0;
            dph_q    <= 1'b0;
            state_q  <= S_ADDR;
          end
        end
        S_ADDR, S_BURST, S_LAST: begin
          if (dph_q && !bus.HREADY &&
              bus.HRESP == ERROR) begin
            htrans_q <= IDLE;
            state_q  <= S_ERR;
          end else if (bus.HREADY) begin
            if (dph_q && !hwrite_q) begin
              rd_data_q  <= bus.HRDATA;
              rd_valid_q <= 1'b1;
            end
            dph_q <= act;
            if (act && hwrite_q) begin
              hwdata_q <= bus.wr_data;
              wreq_q   <= 1'b1;
            end
            if (state_q == S_LAST) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else if (htrans_q == BUSY) begin
              htrans_q <= hold ? BUSY : SEQ;
            end else if (left_q == '0) begin
              htrans_q <= IDLE;
              state_q  <= S_LAST;
            end else begin
              haddr_q  <= addr_d;
              left_q   <= left_q - 1'b1;
              htrans_q <= hold ? BUSY : SEQ;
              state_q  <= S_BURST;
            end
          end
        end
        S_ERR: begin
          if (bus.HREADY) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            dph_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.wr_data_req = wreq_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.HADDR       = haddr_q;
  assign bus.HBURST      = hburst_q;
  assign bus.HSIZE       = hsize_q;
  assign bus.HTRANS      = htrans_q;
  assign bus.HWRITE      = hwrite_q;
  assign bus.HWDATA      = hwdata_q;
endmodule

// File: tb/tb_ahb3lite_master.sv
// Bench for ahb3lite_master: directed commands, a reactive slave
// with wait/error injection, and queue-based expectations.
module tb_ahb3lite_master;
  import ahb3lite_pkg::*;

  logic clk;
  logic rst;

  ahb3lite_master_if #(.MAX_LEN(16)) bus();

  ahb3lite_master #(.MAX_LEN(16)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;
  logic [40:0] aexp[$];
  logic [31:0] rexp[$];
  logic [31:0] wexp[$];
  logic [31:0] wsrc[$];
  int wptr = 0;
  int wreq_cnt = 0;
  int done_cnt = 0;
  int err_beat = 0;
  int wait_beat = 0;
  int wait_n = 0;

  bit          dp_active = 0;
  bit          dp_write = 0;
  logic [31:0] dp_addr = '0;
  int          dp_beat = 0;
  int          dp_cyc = 0;

  task automatic chk(string tag, logic [40:0] obs,
                     logic [40:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(logic [31:0] a);
    if (a < 32'h40)
      return 32'h11 * (((a >> 2) & 32'd7) + 32'd1);
    return ~a;
  endfunction

  function automatic int beats_of(HBURST_Type b, int len);
    case (b)
      SINGLE:          return 1;
      INCR:            return (len == 0) ? 1 : len;
      WRAP4, INCR4:    return 4;
      WRAP8, INCR8:    return 8;
      default:         return 16;
    endcase
  endfunction

  function automatic logic [31:0] nxt(logic [31:0] a,
      HBURST_Type b, logic [2:0] sz);
    logic [31:0] step, span, base;
    int n;
    step = 32'd1 << sz;
    case (b)
      WRAP4:   n = 4;
      WRAP8:   n = 8;
      WRAP16:  n = 16;
      default: n = 0;
    endcase
    if (n == 0) return a + step;
    span = step * n;
    base = a - (a % span);
    return base + ((a - base + step) % span);
  endfunction

  // Slave: tracks data phases, injects waits/errors, supplies data
  initial begin
    bit s_acc, s_rdy, s_wr;
    logic [31:0] s_addr;
    HTRANS_state s_tr;
    bus.HREADY  = 1'b1;
    bus.HRESP   = OKAY;
    bus.HRDATA  = '0;
    bus.wr_data = '0;
    forever begin
      @(negedge clk);
      s_rdy  = bus.HREADY;
      s_acc  = (bus.HTRANS inside {NONSEQ, SEQ}) && s_rdy;
      s_addr = bus.HADDR;
      s_wr   = bus.HWRITE;
      s_tr   = bus.HTRANS;
      @(posedge clk);
      #1;
      if (rst) begin
        dp_active = 0;
        dp_cyc = 0;
      end else if (s_rdy) begin
        if (s_acc) begin
          dp_active = 1;
          dp_addr = s_addr;
          dp_write = s_wr;
          dp_cyc = 0;
          dp_beat = (s_tr == NONSEQ) ? 1 : dp_beat + 1;
        end else begin
          dp_active = 0;
        end
      end else if (dp_active) begin
        dp_cyc++;
      end
      if (bus.wr_data_req) wptr++;
      bus.wr_data = (wptr < wsrc.size()) ? wsrc[wptr] : 32'h0;
      bus.HREADY = 1'b1;
      bus.HRESP  = OKAY;
      if (dp_active && dp_beat == err_beat) begin
        bus.HRESP  = ERROR;
        bus.HREADY = (dp_cyc != 0);
      end else if (dp_active && dp_beat == wait_beat &&
                   dp_cyc < wait_n) begin
        bus.HREADY = 1'b0;
      end
      bus.HRDATA = (dp_active && !dp_write) ?
                   rd_fn(dp_addr) : 32'h0;
    end
  end

  // Monitor: compares bus activity against the expectation queues
  initial begin
    bit p_ok, p_wait, p_err;
    logic [31:0] p_addr, p_wd;
    HTRANS_state p_tr;
    logic [40:0] got;
    p_ok = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_ok = 0;
        continue;
      end
      if (p_ok && p_err) begin
        chk("err_idle", bus.HTRANS, IDLE);
      end else if (p_ok && p_wait) begin
        chk("hold_addr", bus.HADDR, p_addr);
        chk("hold_trans", bus.HTRANS, p_tr);
        chk("hold_wdata", bus.HWDATA, p_wd);
      end
      if ((bus.HTRANS inside {NONSEQ, SEQ}) && bus.HREADY) begin
        chk("addr_extra", aexp.size() != 0, 1);
        if (aexp.size() != 0) begin
          got = aexp.pop_front();
          chk("addr_phase", {bus.HBURST, bus.HSIZE, bus.HWRITE,
                             bus.HTRANS, bus.HADDR}, got);
        end
      end
      if (dp_active && dp_write && bus.HREADY &&
          bus.HRESP == OKAY) begin
        chk("wdata_extra", wexp.size() != 0, 1);
        if (wexp.size() != 0)
          chk("hwdata", bus.HWDATA, wexp.pop_front());
      end
      if (bus.rd_valid) begin
        chk("rd_extra", rexp.size() != 0, 1);
        if (rexp.size() != 0)
          chk("rd_data", bus.rd_data, rexp.pop_front());
      end
      if (bus.wr_data_req) wreq_cnt++;
      if (bus.done) done_cnt++;
      p_ok   = 1;
      p_wait = !bus.HREADY && bus.HRESP == OKAY;
      p_err  = !bus.HREADY && bus.HRESP == ERROR;
      p_addr = bus.HADDR;
      p_tr   = bus.HTRANS;
      p_wd   = bus.HWDATA;
    end
  end

  int wreq_exp;
  int d0;

  task automatic setup(bit wr, HBURST_Type b, logic [2:0] sz,
      logic [31:0] a, int len, int eb, int wb, int wn);
    int nb, n_addr, n_ok;
    logic [31:0] ad, d;
    HTRANS_state tr;
    err_beat  = eb;
    wait_beat = wb;
    wait_n    = wn;
    nb     = beats_of(b, len);
    n_addr = (eb != 0) ? eb : nb;
    n_ok   = (eb != 0) ? eb - 1 : nb;
    wreq_exp = wreq_cnt + (wr ? n_addr : 0);
    ad = a;
    for (int i = 0; i < nb; i++) begin
      tr = (i == 0) ? NONSEQ : SEQ;
      if (i < n_addr)
        aexp.push_back({b, sz, wr, tr, ad});
      if (i < n_ok) begin
        if (wr) begin
          d = $urandom;
          wsrc.push_back(d);
          wexp.push_back(d);
        end else begin
          rexp.push_back(rd_fn(ad));
        end
      end
      ad = nxt(ad, b, sz);
    end
    bus.cmd_write = wr;
    bus.cmd_burst = b;
    bus.cmd_size  = sz;
    bus.cmd_addr  = a;
    bus.cmd_len   = 5'(len);
  endtask

  task automatic issue();
    @(negedge clk);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    #1 bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("cmd_ready_busy", bus.cmd_ready, 0);
  endtask

  task automatic finish_cmd(bit exp_err);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", done_cnt != d0, 1);
    chk("done_once", done_cnt - d0, 1);
    chk("error_flag", bus.error, exp_err);
    chk("addr_left", aexp.size(), 0);
    chk("rd_left", rexp.size(), 0);
    chk("wd_left", wexp.size(), 0);
    chk("wreq_count", wreq_cnt, wreq_exp);
  endtask

  task automatic run_cmd(bit wr, HBURST_Type b, logic [2:0] sz,
      logic [31:0] a, int len, int eb, int wb, int wn);
    setup(wr, b, sz, a, len, eb, wb, wn);
    d0 = done_cnt;
    issue();
    finish_cmd(eb != 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_burst = SINGLE;
    bus.cmd_size  = '0;
    bus.cmd_len   = '0;
`ifdef AHB_MASTER_BUSY_EN
    bus.cmd_hold  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_htrans", bus.HTRANS, IDLE);
    chk("rst_haddr", bus.HADDR, 0);
    chk("rst_hburst", bus.HBURST, SINGLE);
    chk("rst_hsize", bus.HSIZE, 0);
    chk("rst_hwrite", bus.HWRITE, 0);
    chk("rst_hwdata", bus.HWDATA, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_flags", {bus.rd_valid, bus.done, bus.error,
                      bus.wr_data_req}, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    #2 rst = 1'b0;

    run_cmd(1, SINGLE, 3'd2, 32'h100, 0, 0, 0, 0);
    run_cmd(0, INCR4, 3'd2, 32'h20, 0, 0, 0, 0);
    run_cmd(0, WRAP4, 3'd2, 32'h38, 0, 0, 0, 0);
    run_cmd(1, INCR, 3'd2, 32'h400, 3, 0, 2, 2);
    run_cmd(1, WRAP8, 3'd1, 32'h10E, 0, 0, 0, 0);
    run_cmd(1, INCR, 3'd0, 32'h7, 5, 0, 3, 1);
    run_cmd(0, INCR8, 3'd2, 32'h80, 0, 3, 0, 0);
    run_cmd(0, SINGLE, 3'd2, 32'h44, 0, 0, 0, 0);
    run_cmd(0, WRAP16, 3'd0, 32'h5, 0, 0, 16, 1);
    run_cmd(1, INCR, 3'd2, 32'h500, 0, 0, 0, 0);

    // Asynchronous reset in the middle of an INCR16 read
    setup(0, INCR16, 3'd2, 32'h200, 0, 0, 0, 0);
    issue();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_htrans", bus.HTRANS, IDLE);
    chk("arst_haddr", bus.HADDR, 0);
    chk("arst_hburst", bus.HBURST, SINGLE);
    chk("arst_hwdata", bus.HWDATA, 0);
    chk("arst_flags", {bus.rd_valid, bus.done, bus.error,
                       bus.wr_data_req}, 0);
    aexp.delete();
    rexp.delete();
    wexp.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("arst_cmd_ready", bus.cmd_ready, 1);

    run_cmd(0, INCR4, 3'd1, 32'h300, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end
endmodule

// File: doc/ahb3lite_master.md
Name: ahb3lite_master

Overview:
AHB-Lite bus master that sits directly upstream of ahb3lite_slave. It accepts one burst command at a time from a local requester and drives HADDR/HBURST/HSIZE/HTRANS/HWRITE/HWDATA with pipelined address and data phases. It consumes HREADY/HRESP/HRDATA and returns read data and completion/error status. It uses the HBURST_Type, HTRANS_state and HRESP_state types from ahb3lite_pkg.

Parameters:
MAX_LEN, 16, maximum beats for INCR commands; cmd_len width is $clog2(MAX_LEN)+1.

Ports:
HCLK  input  1  bus clock
HRESET  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid&cmd_ready
cmd_addr  input  32  start address, must be aligned to cmd_size
cmd_write  input  1  1=write, 0=read
cmd_burst  input  HBURST_Type  SINGLE/INCR/WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16
cmd_size  input  3  HSIZE value, 0..2 only
cmd_len  input  $clog2(MAX_LEN)+1  beat count for INCR (1..MAX_LEN); ignored otherwise
wr_data  input  32  write data for the current data-phase beat
wr_data_req  output  1  pulse: wr_data sampled into HWDATA this cycle
rd_data  output  32  captured HRDATA
rd_valid  output  1  one-cycle pulse per completed read beat
done  output  1  one-cycle pulse at burst end (OKAY or ERROR)
error  output  1  sticky per command; set on ERROR, cleared on next accept
HADDR  output  32  address
HBURST  output  HBURST_Type  burst type
HSIZE  output  3  transfer size
HTRANS  output  HTRANS_state  transfer type
HWRITE  output  1  direction
HWDATA  output  32  write data
HREADY  input  1  slave ready (HREADYOUT)
HRESP  input  HRESP_state  slave response
HRDATA  input  32  slave read data

Behaviour:
- Reset (async, any state): state=IDLE; HTRANS=IDLE, HADDR=0, HBURST=SINGLE, HSIZE=0, HWRITE=0, HWDATA=0; rd_data=0; rd_valid=done=error=wr_data_req=0. Outstanding beats are discarded.
- Beats: SINGLE=1, INCRn/WRAPn=n, INCR=cmd_len (0 is treated as 1).
- States: IDLE, ADDR, BURST, LAST, ERR.
- IDLE: on accept, latch command, clear error; next cycle → ADDR, HTRANS=NONSEQ, HADDR=cmd_addr.
- Pipelining: beat k's address phase overlaps beat k-1's data phase. Both advance only on a cycle where HREADY=1; when HREADY=0 all bus outputs (incl. HWDATA) hold.
- ADDR/BURST: on HREADY=1, if more beats remain, issue next address with HTRANS=SEQ (state BURST). After the last address → LAST with HTRANS=IDLE.
- LAST: on HREADY=1 the final data phase completes → pulse done → IDLE. Back-to-back commands therefore have ≥1 IDLE bus cycle.
- Address arithmetic: increment = 1<<HSIZE. WRAPn: boundary = n·increment; the low log2(boundary) bits wrap and the upper bits are unchanged. INCR bursts are not checked for 1 KB crossing (requester's responsibility).
- Write: wr_data_req pulses in the cycle the data phase starts (the cycle after the beat's address phase is accepted). HWDATA<=wr_data that cycle and then holds until HREADY=1.
- Read: on HREADY=1 in a read data phase, rd_data<=HRDATA and rd_valid=1 next cycle.
- Error: HRESP=ERROR with HREADY=0 (first error cycle) → HTRANS=IDLE in the following cycle, cancelling any pending address. State → ERR. On HREADY=1 (second cycle): error=1, done pulse, → IDLE. No rd_valid for the errored beat. Remaining beats are dropped.
- HBURST/HSIZE/HWRITE are constant for the whole burst.
- cmd_valid while not in IDLE is ignored (cmd_ready=0).

Optional Feature:
AHB_MASTER_BUSY_EN: adds input cmd_hold (1 bit).
- With the macro: when cmd_hold=1 during BURST and a next beat remains, HTRANS=BUSY and the address held at the next-beat value. SEQ resumes when cmd_hold=0. BUSY is never issued on the first or after the last beat. A BUSY beat gets a zero-wait OKAY and does not count as a beat.
- Without the macro: the port is absent and BUSY is never generated.

Test Plan:
- SINGLE write addr=0x100, size=2, wr_data=0xDEADBEEF, HREADY=1 → NONSEQ@0x100, one wr_data_req, HWDATA=0xDEADBEEF next cycle, done one cycle later.
- INCR4 read addr=0x20, size=2, HRDATA=0x11..0x44 → HADDR 0x20,0x24,0x28,0x2C (NONSEQ,SEQ,SEQ,SEQ); rd_data 0x11,0x22,0x33,0x44 with rd_valid; done after 4th.
- WRAP4 read addr=0x38, size=2 → HADDR 0x38,0x3C,0x30,0x34.
- INCR len=3 write with HREADY=0 for 2 cycles during beat 2 → HADDR/HTRANS/HWDATA hold during the wait; beat 3 address follows; 3 wr_data_req total.
- INCR8 read, ERROR on beat 3 (HREADY 0 then 1) → HTRANS=IDLE the cycle after the first ERROR cycle; error=1, done pulse, only 2 rd_valid; next command accepted.
- HRESET asserted mid INCR16 beat 5 → outputs at reset values immediately (asynchronous); cmd_ready=1 after release.
